mot_pwm_driver: RTL and testbench
=================================

# mot_pwm_driver

Downstream stage of `drone_top`: consumes the four signed 16-bit motor setpoints `mot_set[3:0]` and drives four ESC PWM lines. It clamps and slew-limits each setpoint once per PWM frame and generates edge-aligned PWM. An arming state machine keeps the motors off until the pilot arms at zero throttle, and ramps them down on disarm.

## Interface
Parameters:
- `PERIOD`, 1000: clocks per PWM frame; also the full-scale duty. Setpoint units are duty counts.
- `SLEW_STEP`, 50: maximum change in applied duty per frame, per motor.
- `ARM_FRAMES`, 8: consecutive qualifying frames required to arm.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1: system clock.
- `resetn`  in  1: synchronous active-low reset.
- `mot_set`  in  signed [15:0] x4: setpoints from `drone_top`; sampled only at the frame boundary.
- `arm`  in  1: pilot arm request, level-sensitive.
- `kill`  in  1: emergency stop, level-sensitive, highest priority.
- `pwm_out`  out  [3:0]: ESC PWM lines.
- `armed`  out  1: high only in state ARMED.
- `frame_tick`  out  1: one-cycle pulse on the cycle after the frame boundary.
- `sat`  out  [3:0]: per-motor flag, set when the last sampled setpoint was clamped.

## Operation
- Frame counter `cnt` runs 0..PERIOD-1 and wraps. The frame boundary (FB) is the cycle where `cnt == PERIOD-1`.
- Clamp at FB: `target[i] = min(max(mot_set[i], 0), PERIOD)`. `sat[i] = (mot_set[i] < 0) || (mot_set[i] > PERIOD)`.
- Slew: `d = target - applied`, computed as 17-bit signed. `applied` changes by `d` clipped to ±SLEW_STEP. `applied` is unsigned, `$clog2(PERIOD+1)` bits wide.
- States:
  - DISARMED: `applied` = 0. Go to ARMING when `arm` = 1.
  - ARMING: at each FB, if all `mot_set` ≤ 0, increment the arm counter; otherwise clear it. When the counter reaches ARM_FRAMES, go to ARMED. If `arm` = 0 on any cycle, go to DISARMED.
  - ARMED: `applied` is slew-updated at each FB. If `arm` = 0, go to RAMPDOWN.
  - RAMPDOWN: `target` is forced to 0 regardless of `mot_set`. `applied` is slewed toward 0 at each FB. When all `applied` = 0 after an FB update, go to DISARMED. If `arm` returns to 1, stay in RAMPDOWN until DISARMED is reached; no re-arm shortcut.
- `kill` = 1 in any state: on the next edge, state = DISARMED, all `applied` = 0, `pwm_out` = 0. While `kill` is held, the state stays DISARMED.
- PWM, registered: `pwm_out[i] <= (state is ARMED or RAMPDOWN) && (cnt < applied[i])`.
  - `applied` = 0 gives a constant low output.
  - `applied` = PERIOD gives a constant high output.
- `sat` and the arm counter update only at FB. `sat` clears on entry to DISARMED.

## Timing
- Reset values: `cnt` = 0, state = DISARMED, `applied` = 0, `pwm_out` = 0, `armed` = 0, `frame_tick` = 0, `sat` = 0. `cnt` restarts at 0 when reset is applied mid-frame.
- Setpoint latency: a `mot_set` value present at FB sets `applied` on the next edge. It is visible on `pwm_out` from the first cycle of the following frame (`cnt` = 0 compare, registered, so it appears one cycle after).
- `armed` rises on the edge after the ARM_FRAMES-th qualifying FB.
- `kill` has one-cycle latency to `pwm_out` low and overrides an FB occurring on the same cycle.
- When `arm` falls on an FB cycle, the ARMED→RAMPDOWN transition takes effect on that edge. The FB update on that same edge uses the ramp-down target of 0.

## Structure
- Package `drone_motor_pkg`:
  - `NUM_MOT` = 4, `MOT_W` = 16.
  - `mot_state_e` enum {DISARMED, ARMING, ARMED, RAMPDOWN}.
  - Clamp/clip helper function.
- Sub-module `mot_pwm_ch`, instantiated NUM_MOT times: per-channel clamp, slew, `applied` register, `sat` flag and PWM comparator.
- The top holds `cnt`, the FSM, the arm counter and `frame_tick`.

## Test plan
All scenarios use PERIOD = 100, SLEW_STEP = 10, ARM_FRAMES = 4.
- Reset, then `arm` = 1 with all `mot_set` = 0 → `armed` rises after the 4th FB and `pwm_out` stays 0.
- ARMING with `mot_set[2]` = 5 at the 3rd FB → counter clears; `armed` rises only after 4 further zero frames.
- ARMED, `mot_set[0]` 0→55 → `applied` goes 10, 20, 30, 40, 50, 55 over six frames. `pwm_out[0]` high-count per frame matches each value.
- ARMED, `mot_set[1]` = −500 → `applied` 0, `sat[1]` = 1. `mot_set[1]` = 3000 → ramps to 100, then `pwm_out[1]` constant high, `sat[1]` = 1.
- `applied` = 40 on all motors, `arm` → 0 → RAMPDOWN gives 30, 20, 10, 0, then DISARMED. `arm` re-asserted during the ramp has no effect.
- `kill` pulsed mid-frame with `applied` = 70 → `pwm_out` = 0 next cycle, `armed` = 0, state DISARMED. Reset asserted mid-frame → all outputs 0 and `cnt` = 0 on the next edge.

Source files
------------

// File: rtl/drone_motor_pkg.sv
// Shared types and helpers for the four-channel ESC PWM driver.
package drone_motor_pkg;

   localparam int NUM_MOT = 4;
   localparam int MOT_W   = 16;

   // Arming state machine states
   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      ARMED    = 2'd2,
      RAMPDOWN = 2'd3
   } mot_state_e;

   // Clip a signed value (one bit wider than a setpoint) into [lo, hi].
   // Used both for the setpoint clamp and for the per-frame slew limit.
   function automatic logic signed [MOT_W:0] clip(
      input logic signed [MOT_W:0] v,
      input logic signed [MOT_W:0] lo,
      input logic signed [MOT_W:0] hi
   );
      logic signed [MOT_W:0] r;
      r = v;
      if (v < lo) begin
         r = lo;
      end else if (v > hi) begin
         r = hi;
      end
      return r;
   endfunction

endpackage

// File: rtl/mot_pwm_ch.sv
// One motor channel: clamp, slew-limit, applied-duty register, saturation
// flag and registered edge-aligned PWM comparator.
module mot_pwm_ch
   import drone_motor_pkg::*;
#(
   parameter int PERIOD    = 1000,
   parameter int SLEW_STEP = 50,
   parameter int CW        = 10,
   parameter int AW        = 10
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic signed [MOT_W-1:0] mot_set,
   input  logic [CW-1:0]           cnt,
   input  logic                    upd_en,     // frame-boundary slew update
   input  logic                    force_zero, // ramp-down: target is 0
   input  logic                    clear,      // applied forced to 0
   input  logic                    sat_upd,    // frame boundary: resample sat
   input  logic                    sat_clr,    // entering DISARMED or kill
   input  logic                    pwm_en,     // output stage enabled
   output logic                    zero_next,  // applied will be 0 after this edge
   output logic                    sat,
   output logic                    pwm
);

   localparam logic signed [MOT_W:0] PERIOD_S = (MOT_W+1)'(PERIOD);
   localparam logic signed [MOT_W:0] SLEW_S   = (MOT_W+1)'(SLEW_STEP);

   logic [AW-1:0]         applied_q, applied_d;
   logic                  sat_q, sat_d;
   logic                  pwm_q, pwm_d;
   logic signed [MOT_W:0] set_ext;
   logic signed [MOT_W:0] target;
   logic signed [MOT_W:0] applied_ext;
   logic signed [MOT_W:0] step;

   // Clamp, slew-limit and compare; all next-state values for this channel
   always_comb begin
      set_ext     = {mot_set[MOT_W-1], mot_set};
      target      = force_zero ? '0 : clip(set_ext, '0, PERIOD_S);
      applied_ext = $signed({{(MOT_W+1-AW){1'b0}}, applied_q});
      step        = clip(target - applied_ext, -SLEW_S, SLEW_S);

      applied_d = applied_q;
      if (clear) begin
         applied_d = '0;
      end else if (upd_en) begin
         applied_d = AW'(applied_ext + step);
      end
      zero_next = (applied_d == '0);

      sat_d = sat_q;
      if (sat_clr) begin
         sat_d = 1'b0;
      end else if (sat_upd) begin
         sat_d = set_ext[MOT_W] || (set_ext > PERIOD_S);
      end

      pwm_d = pwm_en && (AW'(cnt) < applied_q);
   end

   // Channel registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         applied_q <= '0;
         sat_q     <= 1'b0;
         pwm_q     <= 1'b0;
      end else begin
         applied_q <= applied_d;
         sat_q     <= sat_d;
         pwm_q     <= pwm_d;
      end
   end

   assign sat = sat_q;
   assign pwm = pwm_q;

endmodule

// File: rtl/mot_pwm_driver.sv
// Four-channel ESC PWM driver: frame counter, arming FSM and per-motor
// channels. Setpoints are sampled only at the frame boundary (cnt == PERIOD-1).
module mot_pwm_driver
   import drone_motor_pkg::*;
#(
   parameter int PERIOD     = 1000,
   parameter int SLEW_STEP  = 50,
   parameter int ARM_FRAMES = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic signed [MOT_W-1:0] mot_set [NUM_MOT],
   input  logic                    arm,
   input  logic                    kill,
   output logic [NUM_MOT-1:0]      pwm_out,
   output logic                    armed,
   output logic                    frame_tick,
   output logic [NUM_MOT-1:0]      sat,
   output mot_state_e              state_dbg
);

   localparam int CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int AW   = $clog2(PERIOD + 1);
   localparam int AC_W = $clog2(ARM_FRAMES + 1);

   logic [CW-1:0]      cnt_q, cnt_d;
   logic               frame_tick_q, frame_tick_d;
   logic [AC_W-1:0]    arm_cnt_q, arm_cnt_d;
   mot_state_e         state_q, state_d;
   logic               fb;
   logic               all_nonpos;
   logic [NUM_MOT-1:0] zero_next;
   logic               run, upd_en, force_zero, ch_clear, sat_clr, pwm_en;

   // Frame counter and frame tick next values
   always_comb begin
      fb           = (cnt_q == CW'(PERIOD - 1));
      cnt_d        = fb ? '0 : cnt_q + 1'b1;
      frame_tick_d = fb;
      all_nonpos   = 1'b1;
      for (int i = 0; i < NUM_MOT; i++) begin
         if (!(mot_set[i][MOT_W-1] || (mot_set[i] == '0))) begin
            all_nonpos = 1'b0;
         end
      end
   end

   // FSM state register, frame counter and arm counter
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= DISARMED;
         cnt_q        <= '0;
         frame_tick_q <= 1'b0;
         arm_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frame_tick_q <= frame_tick_d;
         arm_cnt_q    <= arm_cnt_d;
      end
   end

   // Next-state logic; kill overrides everything, including a same-cycle boundary
   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      case (state_q)
         DISARMED: begin
            arm_cnt_d = '0;
            if (arm) state_d = ARMING;
         end
         ARMING: begin
            if (!arm) begin
               state_d   = DISARMED;
               arm_cnt_d = '0;
            end else if (fb) begin
               if (all_nonpos) begin
                  arm_cnt_d = arm_cnt_q + 1'b1;
                  if (arm_cnt_d == AC_W'(ARM_FRAMES)) begin
                     state_d   = ARMED;
                     arm_cnt_d = '0;
                  end
               end else begin
                  arm_cnt_d = '0;
               end
            end
         end
         ARMED: begin
            if (!arm) state_d = RAMPDOWN;
         end
         RAMPDOWN: begin
            // Re-asserting arm here is ignored; only a full ramp to 0 exits
            if (fb && (&zero_next)) state_d = DISARMED;
         end
         default: state_d = DISARMED;
      endcase
      if (kill) begin
         state_d   = DISARMED;
         arm_cnt_d = '0;
      end
   end

   // Output decode and channel controls from the current state
   always_comb begin
      run        = (state_q == ARMED) || (state_q == RAMPDOWN);
      upd_en     = fb && run;
      // arm falling on a boundary while ARMED already slews toward 0 on that edge
      force_zero = (state_q == RAMPDOWN) || !arm;
      ch_clear   = kill || !run;
      sat_clr    = kill || ((state_q != DISARMED) && (state_d == DISARMED));
      pwm_en     = run && !kill;
      armed      = (state_q == ARMED);
   end

   for (genvar g = 0; g < NUM_MOT; g++) begin : g_ch
      mot_pwm_ch #(
         .PERIOD    (PERIOD),
         .SLEW_STEP (SLEW_STEP),
         .CW        (CW),
         .AW        (AW)
      ) u_ch (
         .clk        (clk),
         .resetn     (resetn),
         .mot_set    (mot_set[g]),
         .cnt        (cnt_q),
         .upd_en     (upd_en),
         .force_zero (force_zero),
         .clear      (ch_clear),
         .sat_upd    (fb),
         .sat_clr    (sat_clr),
         .pwm_en     (pwm_en),
         .zero_next  (zero_next[g]),
         .sat        (sat[g]),
         .pwm        (pwm_out[g])
      );
   end

   assign frame_tick = frame_tick_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_mot_pwm_driver.sv
// Directed bench for mot_pwm_driver with PERIOD=100, SLEW_STEP=10, ARM_FRAMES=4.
module tb_mot_pwm_driver;
   import drone_motor_pkg::*;

   localparam int PERIOD = 100;
   localparam int SLEW   = 10;
   localparam int ARMF   = 4;

   logic              clk = 1'b0;
   logic              resetn;
   logic              arm;
   logic              kill;
   logic signed [15:0] mot_set [4];
   logic [3:0]        pwm_out;
   logic              armed;
   logic              frame_tick;
   logic [3:0]        sat;
   mot_state_e        state_dbg;

   int checks   = 0;
   int failures = 0;
   int tb_cnt   = 0;
   int hi [4];

   mot_pwm_driver #(
      .PERIOD     (PERIOD),
      .SLEW_STEP  (SLEW),
      .ARM_FRAMES (ARMF)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .mot_set    (mot_set),
      .arm        (arm),
      .kill       (kill),
      .pwm_out    (pwm_out),
      .armed      (armed),
      .frame_tick (frame_tick),
      .sat        (sat),
      .state_dbg  (state_dbg)
   );

   // Clock and reset-aware reference frame counter
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!resetn) tb_cnt <= 0;
      else tb_cnt <= (tb_cnt == PERIOD - 1) ? 0 : tb_cnt + 1;
   end

   // Advance to the next negedge where the reference counter equals n
   task automatic goto_cnt(input int n);
      int g;
      g = 0;
      @(negedge clk);
      while (tb_cnt != n && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (tb_cnt != n) begin
         checks++;
         failures++;
         $display("FAIL goto_cnt timeout got=%0d exp=%0d", tb_cnt, n);
      end
   endtask

   // Count high cycles per motor over one frame of PWM (compares cnt=0..99)
   task automatic measure_frame();
      goto_cnt(1);
      for (int m = 0; m < 4; m++) hi[m] = 0;
      for (int k = 0; k < PERIOD; k++) begin
         if (k > 0) @(negedge clk);
         for (int m = 0; m < 4; m++) if (pwm_out[m]) hi[m]++;
      end
   endtask

   task automatic set_all(input logic signed [15:0] v);
      for (int m = 0; m < 4; m++) mot_set[m] = v;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      arm    = 1'b0;
      kill   = 1'b0;
      set_all(16'sd0);
      repeat (3) @(negedge clk);
      checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0000", pwm_out); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%b exp=0", armed); end
      checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
      checks++; if (sat !== 4'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0000", sat); end
      checks++; if (state_dbg !== DISARMED) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, DISARMED); end
      resetn = 1'b1;
   endtask

   task automatic test_arm();
      goto_cnt(10);
      arm = 1'b1;
      @(negedge clk);
      checks++; if (state_dbg !== ARMING) begin failures++; $display("FAIL arm_enter got=%0d exp=%0d", state_dbg, ARMING); end
      for (int k = 1; k <= 4; k++) begin
         goto_cnt(0);
         checks++; if (armed !== (k == 4)) begin failures++; $display("FAIL arm_fb%0d got=%b exp=%b", k, armed, (k == 4)); end
         checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL arm_pwm%0d got=%b exp=0000", k, pwm_out); end
      end
      checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL arm_tick got=%b exp=1", frame_tick); end
      @(negedge clk);
      checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL arm_tick_low got=%b exp=0", frame_tick); end
      measure_frame();
      for (int m = 0; m < 4; m++) begin
         checks++; if (hi[m] != 0) begin failures++; $display("FAIL arm_zero_duty m%0d got=%0d exp=0", m, hi[m]); end
      end
   endtask

   task automatic test_slew();
      int exp_s [6];
      exp_s = '{10, 20, 30, 40, 50, 55};
      goto_cnt(50);
      mot_set[0] = 16'sd55;
      for (int f = 0; f < 6; f++) begin
         measure_frame();
         checks++; if (hi[0] != exp_s[f]) begin failures++; $display("FAIL slew_f%0d got=%0d exp=%0d", f, hi[0], exp_s[f]); end
         checks++; if (hi[1] != 0) begin failures++; $display("FAIL slew_other_f%0d got=%0d exp=0", f, hi[1]); end
      end
   endtask

   task automatic test_sat();
      goto_cnt(50);
      mot_set[1] = -16'sd500;
      goto_cnt(0);
      checks++; if (sat !== 4'b0010) begin failures++; $display("FAIL sat_neg got=%b exp=0010", sat); end
      measure_frame();
      checks++; if (hi[1] != 0) begin failures++; $display("FAIL sat_neg_duty got=%0d exp=0", hi[1]); end
      checks++; if (hi[0] != 55) begin failures++; $display("FAIL sat_m0_hold got=%0d exp=55", hi[0]); end
      goto_cnt(50);
      mot_set[1] = 16'sd3000;
      for (int f = 1; f <= 10; f++) begin
         measure_frame();
         checks++; if (hi[1] != 10 * f) begin failures++; $display("FAIL sat_ramp_f%0d got=%0d exp=%0d", f, hi[1], 10 * f); end
      end
      checks++; if (sat !== 4'b0010) begin failures++; $display("FAIL sat_high got=%b exp=0010", sat); end
   endtask

   task automatic test_rampdown();
      int exp_r [3];
      exp_r = '{30, 20, 10};
      goto_cnt(50);
      set_all(16'sd40);
      repeat (6) measure_frame();
      for (int m = 0; m < 4; m++) begin
         checks++; if (hi[m] != 40) begin failures++; $display("FAIL rd_start m%0d got=%0d exp=40", m, hi[m]); end
      end
      checks++; if (sat !== 4'b0) begin failures++; $display("FAIL rd_sat got=%b exp=0000", sat); end
      goto_cnt(50);
      arm = 1'b0;
      @(negedge clk);
      checks++; if (state_dbg !== RAMPDOWN) begin failures++; $display("FAIL rd_enter got=%0d exp=%0d", state_dbg, RAMPDOWN); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL rd_armed got=%b exp=0", armed); end
      for (int f = 0; f < 3; f++) begin
         measure_frame();
         for (int m = 0; m < 4; m++) begin
            checks++; if (hi[m] != exp_r[f]) begin failures++; $display("FAIL rd_f%0d m%0d got=%0d exp=%0d", f, m, hi[m], exp_r[f]); end
         end
         if (f == 0) arm = 1'b1;
         if (f == 1) begin
            checks++; if (state_dbg !== RAMPDOWN) begin failures++; $display("FAIL rd_no_rearm got=%0d exp=%0d", state_dbg, RAMPDOWN); end
         end
      end
      checks++; if (state_dbg !== DISARMED) begin failures++; $display("FAIL rd_done got=%0d exp=%0d", state_dbg, DISARMED); end
      @(negedge clk);
      checks++; if (state_dbg !== ARMING) begin failures++; $display("FAIL rd_rearm got=%0d exp=%0d", state_dbg, ARMING); end
      arm = 1'b0;
      set_all(16'sd0);
      @(negedge clk);
      checks++; if (state_dbg !== DISARMED) begin failures++; $display("FAIL rd_drop got=%0d exp=%0d", state_dbg, DISARMED); end
   endtask

   task automatic test_kill();
      goto_cnt(10);
      arm = 1'b1;
      repeat (4) goto_cnt(0);
      checks++; if (armed !== 1'b1) begin failures++; $display("FAIL kill_arm got=%b exp=1", armed); end
      goto_cnt(50);
      set_all(16'sd70);
      repeat (7) measure_frame();
      for (int m = 0; m < 4; m++) begin
         checks++; if (hi[m] != 70) begin failures++; $display("FAIL kill_pre m%0d got=%0d exp=70", m, hi[m]); end
      end
      goto_cnt(30);
      checks++; if (pwm_out !== 4'b1111) begin failures++; $display("FAIL kill_pwm_pre got=%b exp=1111", pwm_out); end
      kill = 1'b1;
      @(negedge clk);
      checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL kill_pwm got=%b exp=0000", pwm_out); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL kill_armed got=%b exp=0", armed); end
      checks++; if (state_dbg !== DISARMED) begin failures++; $display("FAIL kill_state got=%0d exp=%0d", state_dbg, DISARMED); end
      goto_cnt(0);
      checks++; if (state_dbg !== DISARMED) begin failures++; $display("FAIL kill_hold got=%0d exp=%0d", state_dbg, DISARMED); end
      checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL kill_hold_pwm got=%b exp=0000", pwm_out); end
      kill = 1'b0;
      arm  = 1'b0;
      set_all(16'sd0);
   endtask

   task automatic test_arm_clear();
      goto_cnt(10);
      arm = 1'b1;
      repeat (2) goto_cnt(0);
      goto_cnt(50);
      mot_set[2] = 16'sd5;
      goto_cnt(0);
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL clr_fb3 got=%b exp=0", armed); end
      goto_cnt(10);
      mot_set[2] = 16'sd0;
      for (int k = 1; k <= 4; k++) begin
         goto_cnt(0);
         checks++; if (armed !== (k == 4)) begin failures++; $display("FAIL clr_fb%0d got=%b exp=%b", k, armed, (k == 4)); end
      end
   endtask

   task automatic test_reset_mid();
      int ft_n;
      int ft_pos;
      goto_cnt(50);
      mot_set[0] = 16'sd30;
      repeat (3) measure_frame();
      checks++; if (hi[0] != 30) begin failures++; $display("FAIL rst_pre got=%0d exp=30", hi[0]); end
      goto_cnt(20);
      checks++; if (pwm_out !== 4'b0001) begin failures++; $display("FAIL rst_pwm_pre got=%b exp=0001", pwm_out); end
      resetn = 1'b0;
      arm    = 1'b0;
      set_all(16'sd0);
      @(negedge clk);
      checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL rst_pwm got=%b exp=0000", pwm_out); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL rst_armed got=%b exp=0", armed); end
      checks++; if (state_dbg !== DISARMED) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, DISARMED); end
      resetn = 1'b1;
      ft_n   = 0;
      ft_pos = 0;
      for (int i = 1; i <= PERIOD; i++) begin
         @(negedge clk);
         if (frame_tick) begin
            ft_n++;
            ft_pos = i;
         end
      end
      checks++; if (ft_n != 1 || ft_pos != PERIOD) begin failures++; $display("FAIL rst_cnt_restart got=%0d@%0d exp=1@%0d", ft_n, ft_pos, PERIOD); end
   endtask

   initial begin
      test_reset();
      test_arm();
      test_slew();
      test_sat();
      test_rampdown();
      test_kill();
      test_arm_clear();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
